// File: rtl/updown_pkg.sv
// -----------------------------------------------------------------------------
// updown_pkg
// Shared definitions for the up/down counter slice: direction encoding,
// default counter width, default ping-pong limits, and the decode from a
// direction-rule outcome to the next direction value.
// Imported by updown_dir_ctrl, limit_shadow and the counter's top wrapper.
// -----------------------------------------------------------------------------
package updown_pkg;

    // Direction encoding on the counter's c input
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Default counter width and full-range default window
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LO_RST = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] HI_RST = {CNT_W{1'b1}};

    // Which direction rule fired this cycle. Listed in priority order after
    // the two wrap guards, which must win over the window compares because a
    // wrapped Qn compares as if it were inside (or on the wrong side of) the
    // window.
    typedef enum logic [2:0] {
        RULE_HOLD    = 3'd0,
        RULE_WRAP_UP = 3'd1,
        RULE_WRAP_DN = 3'd2,
        RULE_ABOVE   = 3'd3,
        RULE_BELOW   = 3'd4,
        RULE_HIT_HI  = 3'd5,
        RULE_HIT_LO  = 3'd6
    } dir_rule_e;

    // Map the winning rule to the direction register's next value
    function automatic logic rule_to_dir(input dir_rule_e rule, input logic cur);
        logic dir;
        case (rule)
            RULE_WRAP_UP, RULE_ABOVE, RULE_HIT_HI: dir = DIR_DOWN;
            RULE_WRAP_DN, RULE_BELOW, RULE_HIT_LO: dir = DIR_UP;
            RULE_HOLD:                             dir = cur;
            default:                               dir = cur;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/limit_shadow.sv
// -----------------------------------------------------------------------------
// limit_shadow
// Pending (shadow) copy of the window limits. A load with lo < hi captures the
// request and marks it valid; a load with lo >= hi is rejected and latches the
// sticky error flag. The commit strobe from the direction logic consumes the
// pending values; a load arriving in the same cycle as a commit becomes the
// next pending request.
//
// Ports:
//   clk, rst      clock, async active-high reset
//   lo, hi        requested limits
//   load          single-cycle load strobe
//   commit        turn event this cycle (pending values are being consumed)
//   plo, phi      pending limits
//   pv            pending-valid
//   err           sticky invalid-load flag
// -----------------------------------------------------------------------------
module limit_shadow
    import updown_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             load,
    input  logic             commit,
    output logic [WIDTH-1:0] plo,
    output logic [WIDTH-1:0] phi,
    output logic             pv,
    output logic             err
);

    logic [WIDTH-1:0] plo_r;
    logic [WIDTH-1:0] phi_r;
    logic             pv_r;
    logic             err_r;
    logic             load_ok_s;
    logic             load_bad_s;

    // Classify the load request
    always_comb begin
        load_ok_s  = 1'b0;
        load_bad_s = 1'b0;
        if (load) begin
            if (lo < hi) begin
                load_ok_s = 1'b1;
            end else begin
                load_bad_s = 1'b1;
            end
        end else begin
            load_ok_s  = 1'b0;
            load_bad_s = 1'b0;
        end
    end

    // Pending limit storage; only a valid load overwrites it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plo_r <= {WIDTH{1'b0}};
            phi_r <= {WIDTH{1'b1}};
        end else if (load_ok_s) begin
            plo_r <= lo;
            phi_r <= hi;
        end else begin
            plo_r <= plo_r;
            phi_r <= phi_r;
        end
    end

    // Pending-valid: a new valid load wins over a commit in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_r <= 1'b0;
        end else if (load_ok_s) begin
            pv_r <= 1'b1;
        end else if (commit) begin
            pv_r <= 1'b0;
        end else begin
            pv_r <= pv_r;
        end
    end

    // Sticky error, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (load_bad_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign plo = plo_r;
    assign phi = phi_r;
    assign pv  = pv_r;
    assign err = err_r;

endmodule

// File: rtl/updown_dir_ctrl.sv
// -----------------------------------------------------------------------------
// updown_dir_ctrl
// Direction sequencer for the synchronous up/down counter. Predicts the
// counter's next value from Q and the current direction, and turns the
// counter around at the active window limits so it ping-pongs inside
// [alo, ahi]. New limits are staged in limit_shadow and promoted to active
// on the cycle the direction register changes.
//
// Ports:
//   clk, rst   clock and async active-high reset, shared with the counter
//   Q          current counter value
//   lo, hi     requested limits, sampled on load
//   load       single-cycle load strobe
//   c          registered direction (0 = up, 1 = down)
//   turn       one-cycle pulse the cycle after c changes
//   sweeps     saturating count of down->up turns (completed round trips)
//   err        sticky flag: a load carried lo >= hi
// -----------------------------------------------------------------------------
module updown_dir_ctrl
    import updown_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   Q,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic               load,
    output logic               c,
    output logic               turn,
    output logic [SWEEP_W-1:0] sweeps,
    output logic               err
);

    localparam logic [WIDTH-1:0]   Q_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   Q_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   Q_ZERO  = {WIDTH{1'b0}};
    localparam logic [SWEEP_W-1:0] SW_ONE  = {{(SWEEP_W-1){1'b0}}, 1'b1};
    localparam logic [SWEEP_W-1:0] SW_MAX  = {SWEEP_W{1'b1}};

    logic               c_r;
    logic               c_last_r;
    logic               turn_r;
    logic [SWEEP_W-1:0] sweeps_r;
    logic [WIDTH-1:0]   alo_r;
    logic [WIDTH-1:0]   ahi_r;

    logic [WIDTH-1:0]   qn_s;
    dir_rule_e          rule_s;
    logic               c_next_s;
    logic               turn_evt_s;
    logic               commit_s;
    logic               up_turn_s;

    logic [WIDTH-1:0]   plo_s;
    logic [WIDTH-1:0]   phi_s;
    logic               pv_s;
    logic               err_s;

    // Predicted next counter value, wrapping like the counter does
    always_comb begin
        if (c_r == DIR_DOWN) begin
            qn_s = Q - Q_ONE;
        end else begin
            qn_s = Q + Q_ONE;
        end
    end

    // Pick the winning direction rule. The wrap guards come first: a wrapped
    // Qn would otherwise look like it landed on the far side of the window.
    always_comb begin
        rule_s = RULE_HOLD;
        if ((c_r == DIR_UP) && (Q == Q_MAX)) begin
            rule_s = RULE_WRAP_UP;
        end else if ((c_r == DIR_DOWN) && (Q == Q_ZERO)) begin
            rule_s = RULE_WRAP_DN;
        end else if (qn_s > ahi_r) begin
            rule_s = RULE_ABOVE;
        end else if (qn_s < alo_r) begin
            rule_s = RULE_BELOW;
        end else if ((c_r == DIR_UP) && (qn_s == ahi_r)) begin
            rule_s = RULE_HIT_HI;
        end else if ((c_r == DIR_DOWN) && (qn_s == alo_r)) begin
            rule_s = RULE_HIT_LO;
        end else begin
            rule_s = RULE_HOLD;
        end
    end

    // Next direction, turn detection and commit strobe
    always_comb begin
        c_next_s   = rule_to_dir(rule_s, c_r);
        turn_evt_s = (c_next_s != c_r);
        commit_s   = turn_evt_s && pv_s;
        up_turn_s  = (c_last_r == DIR_DOWN) && (c_r == DIR_UP);
    end

    // Direction register and its one-cycle-delayed copy for turn reporting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_r      <= DIR_UP;
            c_last_r <= DIR_UP;
        end else begin
            c_r      <= c_next_s;
            c_last_r <= c_r;
        end
    end

    // Turn pulse: high the cycle after the direction register changed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turn_r <= 1'b0;
        end else begin
            turn_r <= (c_r != c_last_r);
        end
    end

    // Round-trip counter, bumped alongside the turn pulse of a down->up turn
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweeps_r <= {SWEEP_W{1'b0}};
        end else if (up_turn_s && (sweeps_r != SW_MAX)) begin
            sweeps_r <= sweeps_r + SW_ONE;
        end else begin
            sweeps_r <= sweeps_r;
        end
    end

    // Active limits: promoted from the shadow on the cycle c changes, so
    // the next evaluation already uses the new window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alo_r <= Q_ZERO;
            ahi_r <= Q_MAX;
        end else if (commit_s) begin
            alo_r <= plo_s;
            ahi_r <= phi_s;
        end else begin
            alo_r <= alo_r;
            ahi_r <= ahi_r;
        end
    end

    limit_shadow #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .lo     (lo),
        .hi     (hi),
        .load   (load),
        .commit (turn_evt_s),
        .plo    (plo_s),
        .phi    (phi_s),
        .pv     (pv_s),
        .err    (err_s)
    );

    assign c      = c_r;
    assign turn   = turn_r;
    assign sweeps = sweeps_r;
    assign err    = err_s;

endmodule

// File: tb/tb_updown_dir_ctrl.sv
module tb_updown_dir_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] q_in;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       load;
    logic       c;
    logic       turn;
    logic [7:0] sweeps;
    logic       err;
    logic       c2;
    logic       turn2;
    logic [1:0] sweeps2;
    logic       err2;

    logic       use_cnt;
    logic [3:0] q_ol;
    logic [3:0] q_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] q;
        logic [3:0] lo;
        logic [3:0] hi;
        logic       ld;
        logic       c;
        logic       turn;
        logic [7:0] sw;
        logic       err;
    } vec_t;

    typedef struct {
        logic       c;
        logic       turn;
        logic [7:0] sw;
        logic [1:0] sw2;
        logic       err;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];

    assign q_in = use_cnt ? q_cnt : q_ol;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model driven by the DUT's direction
    always @(posedge clk or posedge rst) begin
        if (rst) q_cnt <= 4'd0;
        else     q_cnt <= c ? (q_cnt - 4'd1) : (q_cnt + 4'd1);
    end

    updown_dir_ctrl #(.WIDTH(4), .SWEEP_W(8)) u_dut (
        .clk(clk), .rst(rst), .Q(q_in), .lo(lo), .hi(hi), .load(load),
        .c(c), .turn(turn), .sweeps(sweeps), .err(err)
    );

    updown_dir_ctrl #(.WIDTH(4), .SWEEP_W(2)) u_sat (
        .clk(clk), .rst(rst), .Q(q_in), .lo(lo), .hi(hi), .load(load),
        .c(c2), .turn(turn2), .sweeps(sweeps2), .err(err2)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic logic [1:0] sat2(input int s);
        return (s > 3) ? 2'd3 : 2'(s);
    endfunction

    task automatic add(input logic [3:0] q, input logic [3:0] l, input logic [3:0] h,
                       input logic ld, input logic ec, input logic et,
                       input logic [7:0] es, input logic ee);
        vec_t v;
        v.q = q; v.lo = l; v.hi = h; v.ld = ld;
        v.c = ec; v.turn = et; v.sw = es; v.err = ee;
        vq.push_back(v);
    endtask

    // Pop the oldest expectation and compare against the outputs
    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".c"}, int'(c), int'(e.c));
            chk({tag, ".turn"}, int'(turn), int'(e.turn));
            chk({tag, ".sweeps"}, int'(sweeps), int'(e.sw));
            chk({tag, ".err"}, int'(err), int'(e.err));
            chk({tag, ".sweeps_sat"}, int'(sweeps2), int'(e.sw2));
            chk({tag, ".c_sat"}, int'(c2), int'(e.c));
        end
    endtask

    // Expected full-range closed-loop trajectory after reset (edge k)
    function automatic int traj(input int k);
        int m;
        m = k % 30;
        return (m <= 15) ? m : (30 - m);
    endfunction

    function automatic int c_exp(input int k);
        if (k <= 0) return 0;
        return (traj(k + 1) < traj(k)) ? 1 : 0;
    endfunction

    function automatic int turn_exp(input int k);
        return (c_exp(k - 1) != c_exp(k - 2)) ? 1 : 0;
    endfunction

    function automatic int sweeps_exp(input int k);
        return (k >= 1) ? ((k - 1) / 30) : 0;
    endfunction

    task automatic cl_step(input int k, input logic ld, input logic [3:0] l,
                           input logic [3:0] h, input logic ee);
        exp_t e;
        load = ld; lo = l; hi = h;
        e.c = c_exp(k) != 0;
        e.turn = turn_exp(k) != 0;
        e.sw = 8'(sweeps_exp(k));
        e.sw2 = sat2(sweeps_exp(k));
        e.err = ee;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out($sformatf("cl%0d", k));
        chk($sformatf("cl%0d.q", k), int'(q_cnt), traj(k));
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; lo = 4'd0; hi = 4'd0;
        q_ol = 4'd0; use_cnt = 1'b0;

        // Open-loop vectors: Q driven directly, state carried from row to row
        add(4'd3,  4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        add(4'd14, 4'd0, 4'd0,  1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        add(4'd15, 4'd0, 4'd0,  1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
        add(4'd8,  4'd0, 4'd0,  1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        add(4'd1,  4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        add(4'd0,  4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
        add(4'd15, 4'd0, 4'd0,  1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
        add(4'd0,  4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
        add(4'd7,  4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 8'd2, 1'b0);
        add(4'd7,  4'd9, 4'd3,  1'b1, 1'b0, 1'b0, 8'd2, 1'b1);
        add(4'd5,  4'd3, 4'd9,  1'b1, 1'b0, 1'b0, 8'd2, 1'b1);
        add(4'd8,  4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
        add(4'd14, 4'd0, 4'd0,  1'b0, 1'b1, 1'b0, 8'd2, 1'b1);
        add(4'd15, 4'd0, 4'd0,  1'b0, 1'b1, 1'b1, 8'd2, 1'b1);
        add(4'd10, 4'd0, 4'd0,  1'b0, 1'b1, 1'b0, 8'd2, 1'b1);
        add(4'd4,  4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
        add(4'd3,  4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 8'd3, 1'b1);
        add(4'd8,  4'd0, 4'd0,  1'b0, 1'b1, 1'b0, 8'd3, 1'b1);
        add(4'd9,  4'd0, 4'd0,  1'b0, 1'b1, 1'b1, 8'd3, 1'b1);
        add(4'd1,  4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 8'd3, 1'b1);
        add(4'd1,  4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 8'd4, 1'b1);
        add(4'd12, 4'd0, 4'd0,  1'b0, 1'b1, 1'b0, 8'd4, 1'b1);
        add(4'd12, 4'd0, 4'd0,  1'b0, 1'b1, 1'b1, 8'd4, 1'b1);
        add(4'd11, 4'd2, 4'd12, 1'b1, 1'b1, 1'b0, 8'd4, 1'b1);
        add(4'd11, 4'd4, 4'd6,  1'b1, 1'b1, 1'b0, 8'd4, 1'b1);
        add(4'd4,  4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 8'd4, 1'b1);
        add(4'd3,  4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 8'd5, 1'b1);
        add(4'd5,  4'd0, 4'd0,  1'b0, 1'b1, 1'b0, 8'd5, 1'b1);
        add(4'd6,  4'd2, 4'd12, 1'b1, 1'b1, 1'b1, 8'd5, 1'b1);
        add(4'd5,  4'd1, 4'd14, 1'b1, 1'b0, 1'b0, 8'd5, 1'b1);
        add(4'd4,  4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 8'd6, 1'b1);
        add(4'd11, 4'd0, 4'd0,  1'b0, 1'b1, 1'b0, 8'd6, 1'b1);
        add(4'd13, 4'd0, 4'd0,  1'b0, 1'b1, 1'b1, 8'd6, 1'b1);
        add(4'd2,  4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 8'd6, 1'b1);
        add(4'd13, 4'd0, 4'd0,  1'b0, 1'b1, 1'b1, 8'd7, 1'b1);

        #1 rst = 1'b1;
        #2;
        chk("reset.c", int'(c), 0);
        chk("reset.turn", int'(turn), 0);
        chk("reset.sweeps", int'(sweeps), 0);
        chk("reset.err", int'(err), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            exp_t e;
            q_ol = vq[i].q; lo = vq[i].lo; hi = vq[i].hi; load = vq[i].ld;
            e.c = vq[i].c; e.turn = vq[i].turn; e.sw = vq[i].sw;
            e.sw2 = sat2(int'(vq[i].sw)); e.err = vq[i].err;
            sb.push_back(e);
            @(posedge clk);
            #1;
            compare_out($sformatf("vec%0d", i));
        end
        load = 1'b0;

        // Closed loop with the counter, full range from reset
        rst = 1'b1;
        use_cnt = 1'b1;
        #2 rst = 1'b0;
        for (int k = 1; k <= 83; k++) begin
            if (k == 50) cl_step(k, 1'b1, 4'd9, 4'd3, 1'b1);
            else         cl_step(k, 1'b0, 4'd0, 4'd0, k >= 50);
        end

        // Async reset mid-sweep at Q=7 counting down
        chk("pre_rst.q", int'(q_cnt), 7);
        chk("pre_rst.c", int'(c), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.c", int'(c), 0);
        chk("async_rst.turn", int'(turn), 0);
        chk("async_rst.sweeps", int'(sweeps), 0);
        chk("async_rst.err", int'(err), 0);
        chk("async_rst.q", int'(q_cnt), 0);
        #2 rst = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            cl_step(k, 1'b0, 4'd0, 4'd0, 1'b0);
        end

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
